// File: rtl/stream_rr_merge_pkg.sv
// Shared definitions for the stream_rr_merge slice:
// lock state encoding, clog2 helper, default watchdog limit.
package stream_rr_merge_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int DEFAULT_TIMEOUT = 1024;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_rr_merge_rr_arbiter.sv
// Combinational round-robin arbiter: first set request
// at or after i_ptr, wrapping modulo CHANNELS.
module rr_arbiter
  import stream_rr_merge_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  input  logic                i_en,
  output logic [IDX_W-1:0]    o_grant,
  output logic                o_valid
);

  // Walk from the far end so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      automatic int idx = int'(i_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (i_en && i_req[idx[IDX_W-1:0]]) begin
        o_grant = idx[IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_merge.sv
// Round-robin stb/ack stream merge with optional packet
// lock, output-stall watchdog and sticky exception flags.
module stream_rr_merge
  import stream_rr_merge_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 32,
  parameter int PACKET_LOCK = 0,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  localparam int IDX_W =
    (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] input_data,
  input  logic [CHANNELS-1:0]       input_last,
  input  logic [CHANNELS-1:0]       input_stb,
  output logic [CHANNELS-1:0]       input_ack,
  output logic [WIDTH-1:0]          output_data,
  output logic [IDX_W-1:0]          output_chan,
  output logic                      output_last,
  output logic                      output_stb,
  input  logic                      output_ack,
  input  logic [CHANNELS-1:0]       exception_in,
  input  logic                      exception_clr,
  output logic [CHANNELS-1:0]       exception_src,
  output logic                      exception_timeout,
  output logic                      exception
);

  localparam logic [15:0] TO = TIMEOUT[15:0];

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_data;
  logic [IDX_W-1:0]    r_chan;
  logic                r_last;
  logic [IDX_W-1:0]    r_ptr;
  logic [0:0]          r_state;
  logic [IDX_W-1:0]    r_lock_chan;
  logic [15:0]         r_wd_cnt;
  logic [CHANNELS-1:0] r_exc_src;
  logic                r_exc_to;

  logic                w_locked;
  logic [IDX_W-1:0]    w_arb_grant;
  logic                w_arb_valid;
  logic [IDX_W-1:0]    w_grant;
  logic                w_gvalid;
  logic                w_can_accept;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_sel_last;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic                w_stall;
  logic [15:0]         w_cnt_inc;
  logic                w_wd_hit;
  logic [CHANNELS-1:0] w_ack;

  assign w_locked = (PACKET_LOCK != 0) &&
                    (r_state == ST_LOCKED);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .i_req   (input_stb),
    .i_ptr   (r_ptr),
    .i_en    (!w_locked),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  // A locked channel stays granted while its stb is low.
  always_comb begin
    w_grant  = w_arb_grant;
    w_gvalid = w_arb_valid;
    if (w_locked) begin
      w_grant  = r_lock_chan;
      w_gvalid = input_stb[r_lock_chan];
    end
  end

  assign w_can_accept = !r_out_valid || output_ack;
  assign w_xfer = rst && w_gvalid && w_can_accept;

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_ack      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == IDX_W'(i)) begin
        w_sel_data = input_data[i*WIDTH +: WIDTH];
        w_sel_last = input_last[i];
        w_ack[i]   = w_xfer;
      end
    end
  end

  assign w_ptr_nxt =
    (w_grant == IDX_W'(CHANNELS - 1)) ? '0
                                      : w_grant + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_chan      <= '0;
      r_last      <= 1'b0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_data      <= w_sel_data;
      r_chan      <= w_grant;
      r_last      <= w_sel_last;
      r_ptr       <= w_ptr_nxt;
    end else if (output_ack) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_lock_chan <= '0;
    end else if (w_xfer && PACKET_LOCK != 0) begin
      if (!w_locked && !w_sel_last) begin
        r_state     <= ST_LOCKED;
        r_lock_chan <= w_grant;
      end else if (w_locked && w_sel_last) begin
        r_state     <= ST_IDLE;
      end
    end
  end

  // Flag fires on the edge where the count reaches TO.
  assign w_stall   = r_out_valid && !output_ack;
  assign w_cnt_inc = (&r_wd_cnt) ? r_wd_cnt
                                 : r_wd_cnt + 16'd1;
  assign w_wd_hit  = (TIMEOUT != 0) && w_stall &&
                     (w_cnt_inc == TO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt  <= '0;
      r_exc_src <= '0;
      r_exc_to  <= 1'b0;
    end else begin
      r_wd_cnt  <= w_stall ? w_cnt_inc : 16'd0;
      r_exc_src <= (r_exc_src &
                    {CHANNELS{!exception_clr}}) |
                   exception_in;
      r_exc_to  <= (r_exc_to && !exception_clr) ||
                   w_wd_hit;
    end
  end

  assign input_ack         = w_ack;
  assign output_data       = r_data;
  assign output_chan       = r_chan;
  assign output_last       = r_last;
  assign output_stb        = r_out_valid;
  assign exception_src     = r_exc_src;
  assign exception_timeout = r_exc_to;
  assign exception         = (|r_exc_src) || r_exc_to;

endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed bench: instance A (no lock, TIMEOUT=8) and
// instance B (packet lock) share clock and reset.
module tb_stream_rr_merge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] a_data, b_data;
  logic [3:0]   a_last, b_last;
  logic [3:0]   a_stb, b_stb;
  logic [3:0]   a_iack, b_iack;
  logic [31:0]  a_odata, b_odata;
  logic [1:0]   a_ochan, b_ochan;
  logic         a_olast, b_olast;
  logic         a_ostb, b_ostb;
  logic         a_oack, b_oack;
  logic [3:0]   a_exin, b_exin;
  logic         a_clr, b_clr;
  logic [3:0]   a_exsrc, b_exsrc;
  logic         a_exto, b_exto;
  logic         a_exc, b_exc;

  int checks = 0;
  int failures = 0;

  stream_rr_merge #(
    .CHANNELS(4), .WIDTH(32),
    .PACKET_LOCK(0), .TIMEOUT(8)
  ) u_a (
    .clk(clk), .rst(rst),
    .input_data(a_data), .input_last(a_last),
    .input_stb(a_stb), .input_ack(a_iack),
    .output_data(a_odata), .output_chan(a_ochan),
    .output_last(a_olast), .output_stb(a_ostb),
    .output_ack(a_oack),
    .exception_in(a_exin), .exception_clr(a_clr),
    .exception_src(a_exsrc),
    .exception_timeout(a_exto),
    .exception(a_exc)
  );

  stream_rr_merge #(
    .CHANNELS(4), .WIDTH(32),
    .PACKET_LOCK(1), .TIMEOUT(1024)
  ) u_b (
    .clk(clk), .rst(rst),
    .input_data(b_data), .input_last(b_last),
    .input_stb(b_stb), .input_ack(b_iack),
    .output_data(b_odata), .output_chan(b_ochan),
    .output_last(b_olast), .output_stb(b_ostb),
    .output_ack(b_oack),
    .exception_in(b_exin), .exception_clr(b_clr),
    .exception_src(b_exsrc),
    .exception_timeout(b_exto),
    .exception(b_exc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out_a(input string tag,
                           input logic [1:0] ch,
                           input logic [31:0] d);
    chk({tag, "_stb"}, 32'(a_ostb), 32'd1);
    chk({tag, "_chan"}, 32'(a_ochan), 32'(ch));
    chk({tag, "_data"}, a_odata, d);
  endtask

  task automatic chk_out_b(input string tag,
                           input logic [1:0] ch,
                           input logic [31:0] d,
                           input logic l);
    chk({tag, "_stb"}, 32'(b_ostb), 32'd1);
    chk({tag, "_chan"}, 32'(b_ochan), 32'(ch));
    chk({tag, "_data"}, b_odata, d);
    chk({tag, "_last"}, 32'(b_olast), 32'(l));
  endtask

  initial begin
    a_data = '0; a_last = '0; a_stb = '0;
    a_oack = 1'b0; a_exin = '0; a_clr = 1'b0;
    b_data = '0; b_last = '0; b_stb = '0;
    b_oack = 1'b0; b_exin = '0; b_clr = 1'b0;

    // Reset state, with requests pending
    a_stb = 4'hF;
    a_oack = 1'b1;
    #2;
    chk("rst_ostb", 32'(a_ostb), 32'd0);
    chk("rst_odata", a_odata, 32'd0);
    chk("rst_ochan", 32'(a_ochan), 32'd0);
    chk("rst_olast", 32'(a_olast), 32'd0);
    chk("rst_iack", 32'(a_iack), 32'd0);
    chk("rst_exc", 32'(a_exc), 32'd0);
    chk("rst_exto", 32'(a_exto), 32'd0);
    chk("rst_exsrc", 32'(a_exsrc), 32'd0);
    chk("rst_b_ostb", 32'(b_ostb), 32'd0);
    step();
    step();
    rst = 1'b1;

    // Round robin, all channels active
    for (int i = 0; i < 4; i++) begin
      a_data[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    a_last = 4'hF;
    #1;
    chk("rr_iack_first", 32'(a_iack), 32'h1);
    step();
    chk_out_a("rr0", 2'd0, 32'hA0);
    chk("rr0_iack", 32'(a_iack), 32'h2);
    step();
    chk_out_a("rr1", 2'd1, 32'hA1);
    chk("rr1_iack", 32'(a_iack), 32'h4);
    step();
    chk_out_a("rr2", 2'd2, 32'hA2);
    chk("rr2_iack", 32'(a_iack), 32'h8);
    step();
    chk_out_a("rr3", 2'd3, 32'hA3);
    chk("rr3_iack", 32'(a_iack), 32'h1);
    step();
    chk_out_a("rr4", 2'd0, 32'hA0);
    step();
    chk_out_a("rr5", 2'd1, 32'hA1);
    a_stb = 4'h0;
    #1;
    chk("rr_idle_iack", 32'(a_iack), 32'h0);
    step();
    chk("rr_drain_ostb", 32'(a_ostb), 32'd0);

    // Backpressure on ch2, five words 0x50..0x54
    a_stb = 4'b0100;
    a_last = 4'h0;
    a_data[64 +: 32] = 32'h50;
    #1;
    chk("bp_iack0", 32'(a_iack), 32'h4);
    step();
    chk_out_a("bp_w0", 2'd2, 32'h50);
    a_data[64 +: 32] = 32'h51;
    step();
    chk_out_a("bp_w1", 2'd2, 32'h51);
    a_data[64 +: 32] = 32'h52;
    a_oack = 1'b0;
    #1;
    chk("bp_stall_iack", 32'(a_iack), 32'h0);
    step();
    chk_out_a("bp_hold1", 2'd2, 32'h51);
    chk("bp_hold1_iack", 32'(a_iack), 32'h0);
    step();
    chk_out_a("bp_hold2", 2'd2, 32'h51);
    step();
    chk_out_a("bp_hold3", 2'd2, 32'h51);
    a_oack = 1'b1;
    #1;
    chk("bp_resume_iack", 32'(a_iack), 32'h4);
    step();
    chk_out_a("bp_w2", 2'd2, 32'h52);
    a_data[64 +: 32] = 32'h53;
    step();
    chk_out_a("bp_w3", 2'd2, 32'h53);
    a_data[64 +: 32] = 32'h54;
    step();
    chk_out_a("bp_w4", 2'd2, 32'h54);
    a_stb = 4'h0;
    step();
    chk("bp_done_ostb", 32'(a_ostb), 32'd0);
    chk("bp_no_timeout", 32'(a_exto), 32'd0);

    // Watchdog: one word stalled for 8 cycles
    a_stb = 4'b0001;
    a_data[0 +: 32] = 32'h77;
    a_oack = 1'b0;
    step();
    a_stb = 4'h0;
    chk_out_a("wd_word", 2'd0, 32'h77);
    for (int i = 1; i <= 8; i++) begin
      chk("wd_before", 32'(a_exto), 32'd0);
      step();
    end
    chk("wd_timeout", 32'(a_exto), 32'd1);
    chk("wd_exc", 32'(a_exc), 32'd1);
    chk_out_a("wd_still", 2'd0, 32'h77);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("wd_clr_to", 32'(a_exto), 32'd0);
    chk("wd_clr_exc", 32'(a_exc), 32'd0);
    step();
    chk("wd_no_reset", 32'(a_exto), 32'd0);
    a_oack = 1'b1;
    step();
    chk("wd_drain", 32'(a_ostb), 32'd0);

    // Sticky exceptions
    a_exin = 4'b1000;
    #1;
    chk("exc_not_yet", 32'(a_exc), 32'd0);
    step();
    a_exin = 4'b0000;
    chk("exc_src3", 32'(a_exsrc), 32'h8);
    chk("exc_or", 32'(a_exc), 32'd1);
    step();
    chk("exc_sticky", 32'(a_exsrc), 32'h8);
    a_clr = 1'b1;
    a_exin = 4'b0001;
    step();
    a_clr = 1'b0;
    a_exin = 4'b0000;
    chk("exc_setwins", 32'(a_exsrc), 32'h1);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("exc_cleared", 32'(a_exsrc), 32'h0);
    chk("exc_or_clr", 32'(a_exc), 32'd0);

    // Packet lock on instance B
    b_oack = 1'b1;
    b_stb = 4'b0010;
    b_data[32 +: 32] = 32'h11;
    b_last = 4'b1001;
    b_data[0 +: 32] = 32'hC0;
    b_data[96 +: 32] = 32'hC3;
    #1;
    chk("pl_iack0", 32'(b_iack), 32'h2);
    step();
    chk_out_b("pl_w0", 2'd1, 32'h11, 1'b0);
    b_stb = 4'b1011;
    b_data[32 +: 32] = 32'h12;
    #1;
    chk("pl_lock_iack1", 32'(b_iack), 32'h2);
    step();
    chk_out_b("pl_w1", 2'd1, 32'h12, 1'b0);
    b_stb = 4'b1001;
    #1;
    chk("pl_lock_gap", 32'(b_iack), 32'h0);
    step();
    chk("pl_gap_drain", 32'(b_ostb), 32'd0);
    b_stb = 4'b1011;
    b_data[32 +: 32] = 32'h13;
    b_last = 4'b1011;
    #1;
    chk("pl_lock_iack2", 32'(b_iack), 32'h2);
    step();
    chk_out_b("pl_w2", 2'd1, 32'h13, 1'b1);
    b_stb = 4'b1001;
    #1;
    chk("pl_unlock_iack", 32'(b_iack), 32'h8);
    step();
    chk_out_b("pl_ch3", 2'd3, 32'hC3, 1'b1);
    b_stb = 4'b0001;
    #1;
    chk("pl_ch0_iack", 32'(b_iack), 32'h1);
    step();
    chk_out_b("pl_ch0", 2'd0, 32'hC0, 1'b1);
    b_stb = 4'b0000;
    step();

    // Reset while locked on ch2 with a stalled word
    b_oack = 1'b0;
    b_stb = 4'b0100;
    b_last = 4'b0000;
    b_data[64 +: 32] = 32'h21;
    step();
    chk_out_b("mr_word", 2'd2, 32'h21, 1'b0);
    b_data[64 +: 32] = 32'h22;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_ostb", 32'(b_ostb), 32'd0);
    chk("mr_odata", b_odata, 32'd0);
    chk("mr_ochan", 32'(b_ochan), 32'd0);
    chk("mr_olast", 32'(b_olast), 32'd0);
    chk("mr_iack", 32'(b_iack), 32'd0);
    chk("mr_exc", 32'(b_exc), 32'd0);
    step();
    rst = 1'b1;
    b_oack = 1'b1;
    b_stb = 4'b1010;
    b_last = 4'b1010;
    b_data[32 +: 32] = 32'hE1;
    b_data[96 +: 32] = 32'hE3;
    #1;
    chk("mr_restart_iack", 32'(b_iack), 32'h2);
    step();
    chk_out_b("mr_restart", 2'd1, 32'hE1, 1'b1);
    b_stb = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_rr_merge.md
Name: stream_rr_merge

Overview:
- Merges CHANNELS independent stb/ack input streams onto one stb/ack output stream, using round-robin arbitration with an optional packet lock.
- Each output word carries its source channel index.
- Also aggregates per-source exception flags and an output-stall watchdog into sticky status.
- Sits between the generated process instances and a shared sink, e.g. several producers feeding one rs232_tx or eth_tx stream.

Parameters:
- CHANNELS, 4, number of input streams (2..16).
- WIDTH, 32, data width per stream.
- PACKET_LOCK, 0, 0 = arbitrate every word; 1 = hold grant until a word with last=1 transfers.
- TIMEOUT, 1024, output-stall cycles before the watchdog flag sets; 0 disables the watchdog.
- IDX_W, derived localparam = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- input_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- input_last  in  CHANNELS  end-of-packet marker per channel.
- input_stb  in  CHANNELS  per-channel data valid.
- input_ack  out  CHANNELS  per-channel accept.
- output_data  out  WIDTH  merged data.
- output_chan  out  IDX_W  source channel of output_data.
- output_last  out  1  last marker of the current word.
- output_stb  out  1  output valid.
- output_ack  in  1  sink accept.
- exception_in  in  CHANNELS  per-source exception level.
- exception_clr  in  1  single-cycle pulse that clears sticky status.
- exception_src  out  CHANNELS  sticky per-source exception flags.
- exception_timeout  out  1  sticky watchdog flag.
- exception  out  1  OR of exception_src and exception_timeout.

Behaviour:
- Handshake:
  - A transfer occurs on any cycle where stb=1 and ack=1.
  - Senders keep stb and data stable until acked.
  - The block never withdraws output_stb or changes output_data/chan/last before output_ack.
- Output register: one word (out_valid).
  - can_accept = !out_valid || output_ack.
  - Provides full throughput: one word per cycle is sustained.
- Ack path: input_ack[i] = grant_valid && grant==i && can_accept. This is combinational from output_ack and input_stb.
  - At most one input_ack bit is high in any cycle.
  - input_ack never asserts for a channel whose stb is low.
- Latency: an input transfer in cycle n gives output_stb=1 with that word in cycle n+1.
- Arbitration (PACKET_LOCK=0 or state IDLE):
  - grant = first channel with stb=1, searching from ptr, ptr+1, … modulo CHANNELS.
  - After each input transfer, ptr <= granted index + 1, wrapping CHANNELS-1 -> 0.
- States (PACKET_LOCK=1):
  - IDLE: round-robin as above. A transfer with last=0 -> LOCKED(g).
  - LOCKED(g): only channel g is eligible, even if its stb is low (other channels wait). A transfer from g with last=1 -> IDLE and ptr <= g+1.
  - With PACKET_LOCK=0 the block stays in IDLE permanently.
- Watchdog:
  - 16-bit counter increments each cycle with output_stb=1 and output_ack=0, saturating.
  - Counter clears on any output transfer or when output_stb=0.
  - When the counter reaches TIMEOUT, exception_timeout <= 1.
- Sticky exceptions:
  - exception_src[i] <= 1 while exception_in[i]=1.
  - exception_clr=1 clears exception_src and exception_timeout.
  - Simultaneous set and clear on the same bit: set wins.
  - exception is combinational OR of the registered flags, so it rises one cycle after the cause.
- Reset values (asynchronous, rst=0):
  - out_valid=0, output_stb=0, output_data=0, output_chan=0, output_last=0.
  - ptr=0, state=IDLE, watchdog counter=0.
  - exception_src=0, exception_timeout=0, exception=0; all input_ack=0.
- Reset mid-operation: any in-flight word or open packet is discarded. No partial-packet recovery is attempted.
- Deassertion of rst must be synchronised externally. The block assumes a clean release.

Decomposition:
- Shared package: handshake state encoding (IDLE/LOCKED), the clog2 function, and the default TIMEOUT constant.
- One sub-module: rr_arbiter (CHANNELS request vector, ptr, enable -> grant index and grant_valid), purely combinational and reusable.
- Merge datapath, lock FSM, watchdog and sticky exception logic stay in stream_rr_merge.

Test Plan:
- Round-robin: CHANNELS=4, PACKET_LOCK=0, all stb=1 with data 0xA0+i, output_ack tied 1. Output must be chan 0,1,2,3,0… with data 0xA0..0xA3 repeating, one word per cycle.
- Backpressure: ch2 only, 5 words, output_ack low for 3 cycles mid-stream. output_data must hold stable while stalled; all 5 words must arrive in order with none lost or duplicated.
- Packet lock: PACKET_LOCK=1, ch1 sends 3 words (last on the 3rd) while ch0 and ch3 hold stb=1. Output must be ch1×3, then ch3 (ptr=2 search), then ch0.
- Watchdog: TIMEOUT=8, one word present and output_ack=0 for 8 cycles. exception_timeout and exception must be 1 at the 9th cycle; exception_clr then drops both to 0.
- Exceptions: pulse exception_in[3] for 1 cycle gives exception_src=4'b1000 sticky. exception_clr coincident with exception_in[0]=1 must leave exception_src=4'b0001.
- Reset mid-packet: assert rst while LOCKED on ch2 with output_stb=1. All outputs must go to reset values immediately; after release, arbitration restarts from ch0.
